// File: rtl/seq_game_ctrl.sv
// Sequence-memory game controller: grows a random colour sequence one step
// per round, plays it back on the LED/tone driver, then checks the player's
// button presses against it. It supports classic, reverse-recall and
// speed-up play modes. The phase timer is built in.
module seq_game_ctrl #(
  parameter int NUM_COLORS     = 4,
  parameter int COLOR_W        = 2,
  parameter int DEPTH          = 32,
  parameter int SCORE_W        = 6,
  parameter int TMR_W          = 21,
  parameter int SHOW_TICKS     = 1000000,
  parameter int GAP_TICKS      = 200000,
  parameter int INPUT_TICKS    = 2000000,
  parameter int SPEED_STEP     = 50000,
  parameter int MIN_SHOW_TICKS = 250000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COLOR_W-1:0] in,
  input  logic               in_valid,
  input  logic [COLOR_W-1:0] rand_color,
  input  logic [1:0]         mode,
  input  logic               start_game,
  output logic [COLOR_W-1:0] out,
  output logic               out_ena,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               busy,
  output logic               win,
  output logic               lose,
  output logic               hs
);

  // The sequence store is sized to the full range of the score-width
  // counters. This lets len/i index it directly without truncation.
  localparam int STACK_N = 2 ** SCORE_W;

  // The timer is loaded with N-1. A phase then lasts exactly N cycles,
  // because expiry is detected on the cycle where the count reads zero.
  localparam logic [TMR_W-1:0]   TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0]   SHOW_INIT = TMR_W'(SHOW_TICKS);
  localparam logic [TMR_W-1:0]   GAP_LD    = TMR_W'(GAP_TICKS - 1);
  localparam logic [TMR_W-1:0]   INPUT_LD  = TMR_W'(INPUT_TICKS - 1);
  localparam logic [SCORE_W-1:0] ONE_S     = SCORE_W'(1);
  localparam logic [SCORE_W-1:0] ZERO_S    = '0;
  localparam logic [SCORE_W-1:0] DEPTH_S   = SCORE_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADD, S_SHOW, S_GAP, S_INPUT, S_HOLD, S_END
  } state_t;

  state_t state, state_nx;
  logic [1:0]         mode_r, mode_r_nx;
  logic [SCORE_W-1:0] score_r, score_nx;
  logic [SCORE_W-1:0] high_r, high_nx;
  logic [SCORE_W-1:0] len, len_nx;
  logic [SCORE_W-1:0] idx, idx_nx;
  logic [TMR_W-1:0]   show_r, show_nx;
  logic [TMR_W-1:0]   timer, timer_nx;
  logic               good, good_nx;
  logic [COLOR_W-1:0] out_r, out_nx;
  logic               ena_r, ena_nx;
  logic               win_r, win_nx;
  logic               lose_r, lose_nx;
  logic               hs_r, hs_nx;
  logic               push;

  logic [COLOR_W-1:0] stack [STACK_N];

  logic [31:0]        rand_full;
  logic [COLOR_W-1:0] reduced;
  logic [31:0]        dec;
  logic [TMR_W-1:0]   speed_show;
  logic [TMR_W-1:0]   show_sel;
  logic [SCORE_W-1:0] last;
  logic [SCORE_W-1:0] next_idx;
  logic [SCORE_W-1:0] rev_idx;
  logic [SCORE_W-1:0] score_inc;
  logic [COLOR_W-1:0] expected;
  logic               timer_run;

  assign rand_full = 32'(rand_color);
  assign reduced   = COLOR_W'(rand_full % 32'(NUM_COLORS));
  assign last      = len - ONE_S;
  assign next_idx  = idx + ONE_S;
  assign rev_idx   = last - idx;
  assign score_inc = score_r + ONE_S;
  assign expected  = (mode_r == 2'd1) ? stack[rev_idx] : stack[idx];
  assign show_sel  = (mode_r == 2'd2) ? speed_show : show_r;
  assign timer_run = (state == S_SHOW) || (state == S_GAP) || (state == S_INPUT);

  // Speed-up show time shrinks by one step per completed round.
  // It saturates at the floor rather than wrapping below zero.
  always_comb begin
    dec = 32'(score_r) * 32'(SPEED_STEP);
    if ((32'(SHOW_TICKS) > dec) && ((32'(SHOW_TICKS) - dec) > 32'(MIN_SHOW_TICKS)))
      speed_show = TMR_W'(32'(SHOW_TICKS) - dec);
    else
      speed_show = TMR_W'(MIN_SHOW_TICKS);
  end

  // The sequence store is never cleared. Entries are always written before
  // they are read within a game.
  always_ff @(posedge clk) begin
    if (push)
      stack[len] <= reduced;
  end

  // State and datapath registers; reset returns to an idle, dark display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mode_r  <= 2'd0;
      score_r <= '0;
      high_r  <= '0;
      len     <= '0;
      idx     <= '0;
      show_r  <= SHOW_INIT;
      timer   <= '0;
      good    <= 1'b0;
      out_r   <= '0;
      ena_r   <= 1'b0;
      win_r   <= 1'b0;
      lose_r  <= 1'b0;
      hs_r    <= 1'b0;
    end else begin
      state   <= state_nx;
      mode_r  <= mode_r_nx;
      score_r <= score_nx;
      high_r  <= high_nx;
      len     <= len_nx;
      idx     <= idx_nx;
      show_r  <= show_nx;
      timer   <= timer_nx;
      good    <= good_nx;
      out_r   <= out_nx;
      ena_r   <= ena_nx;
      win_r   <= win_nx;
      lose_r  <= lose_nx;
      hs_r    <= hs_nx;
    end
  end

  // Next-state and phase-entry actions. Display and timer loads are done on
  // the transition, so each phase starts with its outputs already valid.
  always_comb begin
    state_nx  = state;
    mode_r_nx = mode_r;
    score_nx  = score_r;
    high_nx   = high_r;
    len_nx    = len;
    idx_nx    = idx;
    show_nx   = show_r;
    good_nx   = good;
    out_nx    = out_r;
    ena_nx    = ena_r;
    win_nx    = 1'b0;
    lose_nx   = 1'b0;
    hs_nx     = 1'b0;
    push      = 1'b0;
    timer_nx  = (timer_run && (timer != '0)) ? (timer - TMR_ONE) : timer;

    case (state)
      S_IDLE: begin
        if (start_game)
          state_nx = S_START;
      end

      S_START: begin
        if (!start_game) begin
          mode_r_nx = mode;
          score_nx  = '0;
          len_nx    = '0;
          show_nx   = SHOW_INIT;
          state_nx  = S_ADD;
        end
      end

      S_ADD: begin
        push     = 1'b1;
        len_nx   = len + ONE_S;
        idx_nx   = '0;
        show_nx  = show_sel;
        out_nx   = (len == ZERO_S) ? reduced : stack[ZERO_S];
        ena_nx   = 1'b1;
        timer_nx = show_sel - TMR_ONE;
        state_nx = S_SHOW;
      end

      S_SHOW: begin
        if (timer == '0) begin
          ena_nx   = 1'b0;
          timer_nx = GAP_LD;
          state_nx = S_GAP;
        end
      end

      S_GAP: begin
        if (timer == '0) begin
          if (idx == last) begin
            idx_nx   = '0;
            timer_nx = INPUT_LD;
            state_nx = S_INPUT;
          end else begin
            idx_nx   = next_idx;
            out_nx   = stack[next_idx];
            ena_nx   = 1'b1;
            timer_nx = show_r - TMR_ONE;
            state_nx = S_SHOW;
          end
        end
      end

      S_INPUT: begin
        if (timer == '0) begin
          lose_nx  = 1'b1;
          state_nx = S_END;
        end else if (in_valid) begin
          good_nx  = (in == expected);
          out_nx   = in;
          ena_nx   = 1'b1;
          state_nx = S_HOLD;
        end
      end

      S_HOLD: begin
        if (!in_valid) begin
          ena_nx = 1'b0;
          if (!good) begin
            lose_nx  = 1'b1;
            state_nx = S_END;
          end else if (idx == last) begin
            score_nx = score_inc;
            if (score_inc == DEPTH_S) begin
              win_nx   = 1'b1;
              state_nx = S_END;
            end else begin
              state_nx = S_ADD;
            end
          end else begin
            idx_nx   = next_idx;
            timer_nx = INPUT_LD;
            state_nx = S_INPUT;
          end
        end
      end

      S_END: begin
        if (score_r > high_r) begin
          high_nx = score_r;
          hs_nx   = 1'b1;
        end
        state_nx = S_IDLE;
      end

      default: state_nx = S_IDLE;
    endcase
  end

  assign out        = out_r;
  assign out_ena    = ena_r;
  assign score      = score_r;
  assign high_score = high_r;
  assign busy       = (state != S_IDLE);
  assign win        = win_r;
  assign lose       = lose_r;
  assign hs         = hs_r;

endmodule

// File: tb/tb_seq_game_ctrl.sv
// Scoreboard bench for seq_game_ctrl. A driver plays games against a
// behavioural model of the rules and queues the expected display, win, lose
// and high-score events. A monitor pops and compares them as the DUT
// produces them.
module tb_seq_game_ctrl;

  localparam int NC    = 4;
  localparam int CW    = 3;
  localparam int DP    = 3;
  localparam int SW    = 4;
  localparam int TW    = 8;
  localparam int SHOWT = 4;
  localparam int GAPT  = 2;
  localparam int INPT  = 10;
  localparam int STEP  = 1;
  localparam int MINS  = 2;

  localparam int EV_LIT  = 0;
  localparam int EV_WIN  = 1;
  localparam int EV_LOSE = 2;
  localparam int EV_HS   = 3;

  typedef struct {
    int kind;
    int col;
    int width;
    int val;
    int at;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CW-1:0] in_c;
  logic          in_valid;
  logic [CW-1:0] rand_c;
  logic [1:0]    mode;
  logic          start_game;
  logic [CW-1:0] out;
  logic          out_ena;
  logic [SW-1:0] score;
  logic [SW-1:0] high_score;
  logic          busy;
  logic          win;
  logic          lose;
  logic          hs;

  ev_t expq[$];
  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  int  high_m = 0;
  int  plan [DP];

  bit  lit_on = 1'b0;
  int  lit_col = 0;
  int  lit_w = 0;

  seq_game_ctrl #(
    .NUM_COLORS(NC), .COLOR_W(CW), .DEPTH(DP), .SCORE_W(SW), .TMR_W(TW),
    .SHOW_TICKS(SHOWT), .GAP_TICKS(GAPT), .INPUT_TICKS(INPT),
    .SPEED_STEP(STEP), .MIN_SHOW_TICKS(MINS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in(in_c), .in_valid(in_valid),
    .rand_color(rand_c), .mode(mode), .start_game(start_game),
    .out(out), .out_ena(out_ena), .score(score), .high_score(high_score),
    .busy(busy), .win(win), .lose(lose), .hs(hs)
  );

  // Free-running clock and a cycle count used to time-stamp events.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      EV_LIT:  return "lit";
      EV_WIN:  return "win";
      EV_LOSE: return "lose";
      default: return "hs";
    endcase
  endfunction

  task automatic check_output(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input int k, input int c, input int w, input int v, input int a);
    ev_t e;
    e.kind = k; e.col = c; e.width = w; e.val = v; e.at = a;
    expq.push_back(e);
  endtask

  task automatic check_ev(input int k, input int c, input int w, input int v);
    ev_t e;
    bit ok;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_%s: got col=%0d width=%0d val=%0d at cyc=%0d, required no event",
               kname(k), c, w, v, cyc);
      return;
    end
    e = expq.pop_front();
    ok = (e.kind == k);
    if (k == EV_LIT) ok = ok && (c == e.col) && (w == e.width);
    else             ok = ok && (v == e.val);
    if (e.at >= 0)   ok = ok && (cyc == e.at);
    if (!ok) begin
      bad++;
      $display("[TB] FAIL event_%s: got %s col=%0d width=%0d val=%0d cyc=%0d, required %s col=%0d width=%0d val=%0d cyc=%0d",
               kname(e.kind), kname(k), c, w, v, cyc, kname(e.kind), e.col, e.width, e.val, e.at);
    end
  endtask

  // Monitor: turns display pulses and status pulses into events and checks
  // each one against the head of the expectation queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      lit_on = 1'b0;
    end else begin
      if (out_ena && !lit_on) begin
        lit_on = 1'b1; lit_col = int'(out); lit_w = 1;
      end else if (out_ena && lit_on) begin
        lit_w++;
      end else if (!out_ena && lit_on) begin
        lit_on = 1'b0;
        check_ev(EV_LIT, lit_col, lit_w, 0);
      end
      if (win)  check_ev(EV_WIN, 0, 0, int'(score));
      if (lose) check_ev(EV_LOSE, 0, 0, int'(score));
      if (hs)   check_ev(EV_HS, 0, 0, int'(high_score));
    end
  end

  // Guard against a hung run.
  initial begin
    repeat (50000) @(posedge clk);
    $display("[TB] FAIL watchdog: got no end of test after 50000 cycles, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int pick(input int r);
    if (plan[r] >= 0) return plan[r];
    return int'($urandom_range(0, 7));
  endfunction

  task automatic wait_falls(input int n, output int last_fall, output bit ok);
    int cnt = 0;
    int guard = 0;
    logic prev;
    prev = out_ena;
    ok = 1'b1;
    last_fall = cyc;
    while (cnt < n) begin
      @(negedge clk);
      guard++;
      if (prev && !out_ena) begin
        cnt++;
        last_fall = cyc;
      end
      prev = out_ena;
      if (guard > 100 * n + 50) begin
        ok = 1'b0;
        break;
      end
    end
  endtask

  task automatic finish_game(input int s);
    if (s > high_m) begin
      expect_ev(EV_HS, 0, 0, s, -1);
      high_m = s;
    end
  endtask

  // One full game. The model tracks the growing sequence, the expected press
  // order for the mode, the show width, and the score. fail_type:
  // 0 = wrong press, 1 = no press (timeout), 2 = press on the expiry cycle.
  task automatic apply_stimulus(input int m, input int fail_round, input int fail_type, input bit hold_sg);
    int  seq[$];
    int  order[$];
    int  score_m = 0;
    int  cur_rand;
    int  width;
    int  fall;
    int  val;
    int  h;
    int  fail_k;
    bit  ok;
    bit  over = 1'b0;
    bit  aborted = 1'b0;
    mode = 2'(m);
    cur_rand = pick(0);
    rand_c = CW'(cur_rand);
    @(negedge clk); start_game = 1'b1;
    repeat (2) @(negedge clk);
    start_game = 1'b0;
    @(negedge clk); mode = 2'($urandom_range(0, 3));
    for (int r = 1; r <= DP && !over; r++) begin
      seq.push_back(cur_rand % NC);
      width = SHOWT;
      if (m == 2) width = (SHOWT - score_m * STEP > MINS) ? SHOWT - score_m * STEP : MINS;
      foreach (seq[j]) expect_ev(EV_LIT, seq[j], width, 0, -1);
      if (hold_sg && r == 2) start_game = 1'b1;
      wait_falls(r, fall, ok);
      start_game = 1'b0;
      if (!ok) begin
        check_output("playback_timeout", 0, 1);
        aborted = 1'b1;
        over = 1'b1;
        continue;
      end
      order.delete();
      foreach (seq[j]) order.push_back((m == 1) ? seq[r - 1 - j] : seq[j]);
      if (r == fail_round && fail_type != 0) begin
        expect_ev(EV_LOSE, 0, 0, score_m, fall + GAPT + INPT);
        finish_game(score_m);
        over = 1'b1;
        if (fail_type == 2) begin
          repeat (GAPT + INPT - 1) @(negedge clk);
          in_c = CW'(order[0]); in_valid = 1'b1;
          repeat (3) @(negedge clk);
          in_valid = 1'b0;
          repeat (3) @(negedge clk);
        end else begin
          repeat (GAPT + INPT + 4) @(negedge clk);
        end
        continue;
      end
      fail_k = (r == fail_round) ? ((m == 1) ? 0 : int'($urandom_range(0, r - 1))) : -1;
      for (int k = 0; k < r && !over; k++) begin
        repeat ((k == 0) ? GAPT + int'($urandom_range(0, 5)) : 1 + int'($urandom_range(0, 5))) @(negedge clk);
        if (k == fail_k) val = (m == 1) ? seq[k] : (order[k] + 1 + int'($urandom_range(0, 2))) % NC;
        else             val = order[k];
        h = int'($urandom_range(1, 4));
        expect_ev(EV_LIT, val, h, 0, -1);
        if (val != order[k]) begin
          expect_ev(EV_LOSE, 0, 0, score_m, -1);
          finish_game(score_m);
          over = 1'b1;
        end else if (k == r - 1) begin
          score_m++;
          if (score_m == DP) begin
            expect_ev(EV_WIN, 0, 0, score_m, -1);
            finish_game(score_m);
            over = 1'b1;
          end
        end
        in_c = CW'(val); in_valid = 1'b1;
        repeat (h) @(negedge clk);
        if (k == r - 1 && !over && r < DP) begin
          cur_rand = pick(r);
          rand_c = CW'(cur_rand);
        end
        in_valid = 1'b0;
        @(negedge clk);
      end
    end
    if (aborted) begin
      rst_n = 1'b0;
      expq.delete();
      high_m = 0;
      @(negedge clk); rst_n = 1'b1;
    end else begin
      repeat (4) @(negedge clk);
      check_output("busy_after_game", int'(busy), 0);
      check_output("score_after_game", int'(score), score_m);
      check_output("high_after_game", int'(high_score), high_m);
    end
  endtask

  // Test sequence: reset values, directed games, then randomized games.
  initial begin
    in_c = '0; in_valid = 1'b0; rand_c = '0; mode = 2'd0; start_game = 1'b0;
    foreach (plan[j]) plan[j] = -1;
    #1;
    check_output("reset_out", int'(out), 0);
    check_output("reset_out_ena", int'(out_ena), 0);
    check_output("reset_score", int'(score), 0);
    check_output("reset_high", int'(high_score), 0);
    check_output("reset_busy", int'(busy), 0);
    check_output("reset_pulses", int'({win, lose, hs}), 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    plan[0] = 1; plan[1] = 2; plan[2] = 3;
    apply_stimulus(0, 0, 0, 1'b0);

    begin : reset_mid_show
      int guard = 0;
      mode = 2'd0; rand_c = CW'(1);
      @(negedge clk); start_game = 1'b1;
      @(negedge clk); start_game = 1'b0;
      while (!out_ena && guard < 50) begin @(negedge clk); guard++; end
      check_output("show_reached", int'(out_ena), 1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_output("midreset_out_ena", int'(out_ena), 0);
      check_output("midreset_busy", int'(busy), 0);
      check_output("midreset_score", int'(score), 0);
      check_output("midreset_high", int'(high_score), 0);
      high_m = 0;
      @(negedge clk); #2 rst_n = 1'b1;
      repeat (20) @(negedge clk);
    end

    plan[0] = 0; plan[1] = 2; plan[2] = 1;
    apply_stimulus(1, 2, 0, 1'b0);
    apply_stimulus(1, 0, 0, 1'b0);
    foreach (plan[j]) plan[j] = -1;
    apply_stimulus(0, 1, 1, 1'b0);
    apply_stimulus(0, 2, 2, 1'b0);
    apply_stimulus(2, 0, 0, 1'b0);
    plan[0] = 6; plan[1] = 5; plan[2] = 7;
    apply_stimulus(0, 2, 0, 1'b1);
    foreach (plan[j]) plan[j] = -1;

    for (int g = 0; g < 8; g++)
      apply_stimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, DP)),
                     int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));

    repeat (5) @(negedge clk);
    check_output("queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
